// File: rtl/scan_dff_bank.sv
// Parametrised D flip-flop bank with capture enable, manual scan shift and a built-in
// auto-shift controller that exchanges the whole chain with the SI stream on one START.
// Shift direction: SI enters the MSB, bit 0 leaves on SO (LSB first).
// Optional stuck-at overlay on the functional outputs: define FAULT_INJECT_EN.
module scan_dff_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             se_i,
  input  logic             si_i,
  input  logic             start_i,
`ifdef FAULT_INJECT_EN
  input  logic [WIDTH-1:0] fault_mask_i,
  input  logic [WIDTH-1:0] fault_val_i,
`endif
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic             so_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] reg_q, reg_d;

  // Next bank contents: auto-shift wins, then manual scan, then capture, else hold.
  always_comb begin
    reg_d = reg_q;
    if (state_q == StShift) begin
      reg_d = {si_i, reg_q[WIDTH-1:1]};
    end else if (se_i) begin
      reg_d = {si_i, reg_q[WIDTH-1:1]};
    end else if (en_i) begin
      reg_d = d_i;
    end
  end

  // Flop bank state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= RESET_VAL;
    end else begin
      reg_q <= reg_d;
    end
  end

  // Auto-shift controller with registered BUSY/DONE; START outside IDLE is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StShift;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          if (cnt_q == CntLast) begin
            // Counter parks at its last value; it is cleared on the next START.
            state_q <= StFin;
            done_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + CntW'(1);
            busy_q <= 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef FAULT_INJECT_EN
  // Forced bits appear only on Q/QN; the scan path keeps reading the true register.
  assign q_o = (reg_q & ~fault_mask_i) | (fault_val_i & fault_mask_i);
`else
  assign q_o = reg_q;
`endif
  assign qn_o   = ~q_o;
  assign so_o   = reg_q[0];
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
